wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/pipe_pkg.sv | 8 +
 rtl/wb_select.sv | 13 +
 rtl/wb_regfile.sv | 73 +++++++
 tb/tb_wb_regfile.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants for the writeback/register-file slice, the
// MEM/WB pipeline registers and the forwarding unit.
package pipe_pkg;
  localparam int DATA_W     = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/wb_select.sv
// Writeback source mux: load data or ALU result, independent of Regwrite.
module wb_select
  import pipe_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         MemtoReg,
  input  logic [W-1:0] aluresult,
  input  logic [W-1:0] memreadresult,
  output logic [W-1:0] wbdata
);
  assign wbdata = MemtoReg ? memreadresult : aluresult;
endmodule

// File: rtl/wb_regfile.sv
// Architectural register file with writeback select, write-through bypass on
// both read ports, and a committed-writeback counter.
module wb_regfile #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int NREGS  = pipe_pkg::NREGS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Regwrite,
  input  logic                          MemtoReg,
  input  logic [pipe_pkg::REG_ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0]             aluresult,
  input  logic [DATA_W-1:0]             memreadresult,
  input  logic [pipe_pkg::REG_ADDR_W-1:0] rs,
  input  logic [pipe_pkg::REG_ADDR_W-1:0] rt,
  input  logic                          i_tst_cnt_load,
  input  logic [31:0]                   i_tst_cnt_val,
  output logic [DATA_W-1:0]             rsdata,
  output logic [DATA_W-1:0]             rtdata,
  output logic [DATA_W-1:0]             wbdata,
  output logic                          wbvalid,
  output logic [31:0]                   wbcount
);
  import pipe_pkg::*;

  logic [NREGS-1:0][DATA_W-1:0] r_regs;
  logic [31:0]                  r_wbcount;
  logic [DATA_W-1:0]            w_wbdata;
  logic                         w_wbvalid;
  logic                         w_byp_en;

  wb_select #(.W(DATA_W)) u_wb_select (
    .MemtoReg      (MemtoReg),
    .aluresult     (aluresult),
    .memreadresult (memreadresult),
    .wbdata        (w_wbdata)
  );

  assign w_wbvalid = Regwrite && (rd != ZERO_REG);
  // Reset cycle reads the pre-reset contents, so the bypass is suppressed then.
  assign w_byp_en  = w_wbvalid && !rst;

  // Register 0 is never written; its read path is forced to zero regardless.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs <= '0;
    end else if (w_wbvalid) begin
      r_regs[rd] <= w_wbdata;
    end
  end

  // Test preload takes priority over the increment; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbcount <= '0;
    end else if (i_tst_cnt_load) begin
      r_wbcount <= i_tst_cnt_val;
    end else if (w_wbvalid) begin
      r_wbcount <= r_wbcount + 32'd1;
    end
  end

  always_comb begin
    rsdata = (rs == ZERO_REG) ? '0 : r_regs[rs];
    rtdata = (rt == ZERO_REG) ? '0 : r_regs[rt];
    if (w_byp_en && (rs == rd)) rsdata = w_wbdata;
    if (w_byp_en && (rt == rd)) rtdata = w_wbdata;
  end

  assign wbdata  = w_wbdata;
  assign wbvalid = w_wbvalid;
  assign wbcount = r_wbcount;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic against an array-based reference model.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst, Regwrite, MemtoReg, i_tst_cnt_load;
  logic [4:0]  rd, rs, rt;
  logic [31:0] aluresult, memreadresult, i_tst_cnt_val;
  logic [31:0] rsdata, rtdata, wbdata, wbcount;
  logic        wbvalid;

  logic [31:0] ref_regs [0:31];
  logic [31:0] ref_cnt;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst), .Regwrite(Regwrite), .MemtoReg(MemtoReg), .rd(rd),
    .aluresult(aluresult), .memreadresult(memreadresult), .rs(rs), .rt(rt),
    .i_tst_cnt_load(i_tst_cnt_load), .i_tst_cnt_val(i_tst_cnt_val),
    .rsdata(rsdata), .rtdata(rtdata), .wbdata(wbdata), .wbvalid(wbvalid),
    .wbcount(wbcount)
  );

  function automatic logic [31:0] exp_wb();
    return MemtoReg ? memreadresult : aluresult;
  endfunction

  function automatic logic exp_valid();
    return Regwrite && (rd != 5'd0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (!rst && exp_valid() && a == rd) return exp_wb();
    return (a == 5'd0) ? 32'd0 : ref_regs[a];
  endfunction

  task automatic drive(input logic rw, input logic m2r, input logic [4:0] d,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] a, input logic [4:0] b);
    Regwrite = rw; MemtoReg = m2r; rd = d; aluresult = alu;
    memreadresult = mem; rs = a; rt = b;
    #1;
  endtask

  // Apply the architectural effect of the current inputs, then clock.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
      ref_cnt = 32'd0;
    end else begin
      if (exp_valid()) ref_regs[rd] = exp_wb();
      if (i_tst_cnt_load) ref_cnt = i_tst_cnt_val;
      else if (exp_valid()) ref_cnt = ref_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (wbcount !== 32'd0) begin
      n_fail++; $display("FAIL reset_wbcount got %h want %h", wbcount, 32'd0);
    end
    for (int i = 0; i < 32; i += 7) begin
      drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'(i), 5'(31 - i));
      n_chk++;
      if (rsdata !== 32'd0 || rtdata !== 32'd0) begin
        n_fail++; $display("FAIL reset_read r%0d got %h/%h want 0", i, rsdata, rtdata);
      end
    end
  endtask

  task automatic test_basic_write();
    drive(1'b1, 1'b0, 5'd5, 32'h12345678, 32'h0, 5'd1, 5'd2);
    n_chk++;
    if (wbvalid !== 1'b1 || wbdata !== 32'h12345678) begin
      n_fail++; $display("FAIL basic_wb got %b/%h want 1/12345678", wbvalid, wbdata);
    end
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0);
    n_chk++;
    if (rsdata !== 32'h12345678 || wbcount !== 32'd1) begin
      n_fail++; $display("FAIL basic_read got %h cnt %h want 12345678 cnt 1", rsdata, wbcount);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 1'b1, 5'd7, 32'h0BADF00D, 32'hDEADBEEF, 5'd7, 5'd7);
    n_chk++;
    if (rsdata !== 32'hDEADBEEF || rtdata !== 32'hDEADBEEF || wbdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass got %h/%h wb %h want deadbeef", rsdata, rtdata, wbdata);
    end
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd5);
    n_chk++;
    if (rsdata !== 32'hDEADBEEF || rtdata !== 32'h12345678 || wbcount !== 32'd2) begin
      n_fail++; $display("FAIL bypass_commit got %h/%h cnt %h", rsdata, rtdata, wbcount);
    end
  endtask

  task automatic test_zero_reg();
    logic [31:0] cnt0;
    cnt0 = wbcount;
    drive(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0);
    n_chk++;
    if (wbvalid !== 1'b0 || rsdata !== 32'd0 || rtdata !== 32'd0) begin
      n_fail++; $display("FAIL zero_wbvalid got %b rs %h rt %h want 0", wbvalid, rsdata, rtdata);
    end
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    n_chk++;
    if (rsdata !== 32'd0 || wbcount !== cnt0) begin
      n_fail++; $display("FAIL zero_read got %h cnt %h want 0 cnt %h", rsdata, wbcount, cnt0);
    end
  endtask

  task automatic test_no_regwrite();
    logic [31:0] cnt0;
    cnt0 = wbcount;
    drive(1'b1, 1'b0, 5'd3, 32'h33333333, 32'h0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd3, 32'hAAAA5555, 32'h0, 5'd3, 5'd3);
    n_chk++;
    if (wbvalid !== 1'b0 || rsdata !== 32'h33333333 || wbdata !== 32'hAAAA5555) begin
      n_fail++; $display("FAIL noreg_bypass got v%b rs %h wb %h", wbvalid, rsdata, wbdata);
    end
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd0);
    n_chk++;
    if (rsdata !== 32'h33333333 || wbcount !== cnt0 + 32'd1) begin
      n_fail++; $display("FAIL noreg_keep got %h cnt %h want 33333333 cnt %h", rsdata, wbcount, cnt0 + 32'd1);
    end
  endtask

  task automatic test_reset_discard();
    drive(1'b1, 1'b0, 5'd9, 32'h1, 32'h0, 5'd0, 5'd0);
    tick();
    rst = 1'b1;
    drive(1'b1, 1'b0, 5'd9, 32'h2, 32'h0, 5'd9, 5'd9);
    n_chk++;
    if (rsdata !== 32'h1 || rtdata !== 32'h1 || wbvalid !== 1'b1) begin
      n_fail++; $display("FAIL rst_cycle_read got %h/%h v%b want 1/1 v1", rsdata, rtdata, wbvalid);
    end
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd5);
    n_chk++;
    if (rsdata !== 32'd0 || rtdata !== 32'd0 || wbcount !== 32'd0) begin
      n_fail++; $display("FAIL rst_discard got %h/%h cnt %h want 0", rsdata, rtdata, wbcount);
    end
    drive(1'b1, 1'b0, 5'd9, 32'h3, 32'h0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd0);
    n_chk++;
    if (rsdata !== 32'h3 || wbcount !== 32'd1) begin
      n_fail++; $display("FAIL rst_first_write got %h cnt %h want 3 cnt 1", rsdata, wbcount);
    end
  endtask

  task automatic test_count_wrap();
    i_tst_cnt_load = 1'b1; i_tst_cnt_val = 32'hFFFFFFFE;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    tick();
    i_tst_cnt_load = 1'b0;
    n_chk++;
    if (wbcount !== 32'hFFFFFFFE) begin
      n_fail++; $display("FAIL wrap_preload got %h want fffffffe", wbcount);
    end
    drive(1'b1, 1'b0, 5'd10, 32'hA, 32'h0, 5'd0, 5'd0);
    tick();
    n_chk++;
    if (wbcount !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL wrap_max got %h want ffffffff", wbcount);
    end
    drive(1'b1, 1'b1, 5'd11, 32'h0, 32'hB, 5'd10, 5'd11);
    tick();
    n_chk++;
    if (wbcount !== 32'h0) begin
      n_fail++; $display("FAIL wrap_zero got %h want 0", wbcount);
    end
  endtask

  task automatic test_random();
    logic [4:0] d, a, b;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 24) == 0);
      d = 5'($urandom_range(0, 31));
      a = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      b = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      drive(1'($urandom), 1'($urandom), d, $urandom, $urandom, a, b);
      n_chk++;
      if (rsdata !== exp_read(rs) || rtdata !== exp_read(rt) || wbdata !== exp_wb() ||
          wbvalid !== exp_valid() || wbcount !== ref_cnt) begin
        n_fail++;
        $display("FAIL rand[%0d] got rs %h rt %h wb %h v%b cnt %h want %h %h %h %b %h", n,
                 rsdata, rtdata, wbdata, wbvalid, wbcount,
                 exp_read(rs), exp_read(rt), exp_wb(), exp_valid(), ref_cnt);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_tst_cnt_load = 1'b0; i_tst_cnt_val = 32'd0;
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    ref_cnt = 32'd0;
    @(negedge clk);
    test_reset();
    test_basic_write();
    test_bypass();
    test_zero_reg();
    test_no_regwrite();
    test_reset_discard();
    test_count_wrap();
    do_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
